// File: rtl/pwm_decoder.sv
// pwm_decoder: measures a PWM waveform in units of step ticks and reports
// the high count (duty) and rise-to-rise period. Constant-level inputs are
// reported through a timeout path with stuck = 1.
module pwm_decoder #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         step,
   input  logic         pwm_in,
   output logic [N-1:0] duty,
   output logic [N:0]   period,
   output logic         stuck,
   output logic         valid
);

   // Largest reportable duty, and the per_cnt value at which a frame with
   // no rise is declared stuck (2^(N+1)-2).
   localparam logic [N-1:0] DUTY_MAX = '1;
   localparam logic [N:0]   TIMEOUT  = {{N{1'b1}}, 1'b0};
   localparam logic [N:0]   CNT_ONE  = {{N{1'b0}}, 1'b1};

   typedef enum logic {
      SYNC = 1'b0,
      MEAS = 1'b1
   } state_t;

   // Clamp an N+1 bit high count into the N bit duty range.
   function automatic logic [N-1:0] sat_duty(input logic [N:0] cnt);
      if (cnt > {1'b0, DUTY_MAX})
         return DUTY_MAX;
      return cnt[N-1:0];
   endfunction

   state_t       state_q, state_d;
   logic         sync_p0, sync_p1;
   logic         s;
   logic         prev, prev_d;
   logic         rise;
   logic [N:0]   per_cnt, per_d;
   logic [N:0]   hi_cnt, hi_d;
   logic [N-1:0] duty_d;
   logic [N:0]   period_d;
   logic         stuck_d;
   logic         valid_d;

   assign s    = sync_p1;
   assign rise = s & ~prev;

   // Two-flop synchronizer bringing the asynchronous pwm_in into clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= pwm_in;
         sync_p1 <= sync_p0;
      end
   end

   // Next-state and report logic; everything holds unless ena is low or a step arrives.
   always_comb begin
      state_d  = state_q;
      prev_d   = prev;
      per_d    = per_cnt;
      hi_d     = hi_cnt;
      duty_d   = duty;
      period_d = period;
      stuck_d  = stuck;
      valid_d  = 1'b0;

      if (!ena) begin
         // Disabled: forget the edge reference and any partial frame.
         state_d = SYNC;
         prev_d  = 1'b1;
         per_d   = '0;
         hi_d    = '0;
      end else if (step) begin
         prev_d = s;
         if (rise && (state_q == SYNC)) begin
            // First rise only establishes the frame reference.
            state_d = MEAS;
            per_d   = CNT_ONE;
            hi_d    = CNT_ONE;
         end else if (rise) begin
            // Rise closes a complete frame; a rise beats a coincident timeout.
            duty_d   = sat_duty(hi_cnt);
            period_d = per_cnt;
            stuck_d  = 1'b0;
            valid_d  = 1'b1;
            per_d    = CNT_ONE;
            hi_d     = CNT_ONE;
         end else if (per_cnt == TIMEOUT) begin
            // No edge for a full window: report the constant level.
            duty_d   = s ? DUTY_MAX : '0;
            period_d = '0;
            stuck_d  = 1'b1;
            valid_d  = 1'b1;
            state_d  = SYNC;
            per_d    = '0;
            hi_d     = '0;
         end else begin
            per_d = per_cnt + CNT_ONE;
            hi_d  = hi_cnt + {{N{1'b0}}, s};
         end
      end
   end

   // State, counters and registered report outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SYNC;
         prev    <= 1'b1;
         per_cnt <= '0;
         hi_cnt  <= '0;
         duty    <= '0;
         period  <= '0;
         stuck   <= 1'b0;
         valid   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev    <= prev_d;
         per_cnt <= per_d;
         hi_cnt  <= hi_d;
         duty    <= duty_d;
         period  <= period_d;
         stuck   <= stuck_d;
         valid   <= valid_d;
      end
   end

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed testbench for pwm_decoder (N = 8).
module tb_pwm_decoder;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         ena = 1'b0;
   logic         step = 1'b0;
   logic         pwm_in = 1'b0;
   logic [N-1:0] duty;
   logic [N:0]   period;
   logic         stuck;
   logic         valid;

   int checks = 0;
   int passed = 0;

   // valid-event capture
   int           cyc = 0;
   int           vcnt = 0;
   int           last_vcyc = 0;
   int           prev_vcyc = 0;
   logic [N-1:0] v_duty;
   logic [N:0]   v_period;
   logic         v_stuck;
   int           gated_bad = 0;
   logic         mon_step;

   // waveform generator configuration
   int gen_mode = 0;   // 0 constant low, 1 constant high, 2 pwm
   int hi_len = 1;
   int lo_len = 1;
   int ph = 0;
   int step_div = 1;
   int sc = 0;

   pwm_decoder #(.N(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .step   (step),
      .pwm_in (pwm_in),
      .duty   (duty),
      .period (period),
      .stuck  (stuck),
      .valid  (valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      mon_step = step;
      #1;
      if (valid === 1'b1) begin
         vcnt++;
         prev_vcyc = last_vcyc;
         last_vcyc = cyc;
         v_duty    = duty;
         v_period  = period;
         v_stuck   = stuck;
         if (!mon_step) gated_bad++;
      end
   end

   task automatic drive_loop();
      forever begin
         @(negedge clk);
         case (gen_mode)
            0: pwm_in = 1'b0;
            1: pwm_in = 1'b1;
            default: begin
               pwm_in = (ph < hi_len);
               ph++;
               if (ph >= hi_len + lo_len) ph = 0;
            end
         endcase
         step = (sc == 0);
         sc++;
         if (sc >= step_div) sc = 0;
      end
   endtask

   task automatic do_reset(input int m_rst, input int m_run, input int hl, input int ll,
                           input int sd);
      gen_mode = m_rst;
      hi_len   = hl;
      lo_len   = ll;
      step_div = sd;
      ena      = 1'b1;
      @(negedge clk);
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      rst      = 1'b0;
      ph       = 0;
      sc       = 0;
      gen_mode = m_run;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      int start;
      start = vcnt;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #2;
         if (vcnt != start) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (duty !== 8'd0) $display("FAIL reset_duty actual=%0d required=0", duty); else passed++;
      checks++; if (period !== 9'd0) $display("FAIL reset_period actual=%0d required=0", period); else passed++;
      checks++; if (stuck !== 1'b0) $display("FAIL reset_stuck actual=%b required=0", stuck); else passed++;
      checks++; if (valid !== 1'b0) $display("FAIL reset_valid actual=%b required=0", valid); else passed++;
   endtask

   task automatic test_loopback();
      bit ok;
      int start;
      do_reset(0, 2, 100, 155, 1);
      start = vcnt;
      repeat (200) @(posedge clk);
      #2;
      checks++; if (vcnt != start) $display("FAIL loop_no_early actual=%0d required=0", vcnt - start); else passed++;
      wait_valid(400, ok);
      checks++; if (!ok) $display("FAIL loop_first_wait actual=timeout required=valid"); else passed++;
      checks++; if (v_duty !== 8'd100) $display("FAIL loop_duty actual=%0d required=100", v_duty); else passed++;
      checks++; if (v_period !== 9'd255) $display("FAIL loop_period actual=%0d required=255", v_period); else passed++;
      checks++; if (v_stuck !== 1'b0) $display("FAIL loop_stuck actual=%b required=0", v_stuck); else passed++;
      @(posedge clk);
      #2;
      checks++; if (valid !== 1'b0) $display("FAIL loop_valid_width actual=%b required=0", valid); else passed++;
      wait_valid(300, ok);
      checks++; if (!ok) $display("FAIL loop_second_wait actual=timeout required=valid"); else passed++;
      checks++; if (last_vcyc - prev_vcyc != 255) $display("FAIL loop_interval actual=%0d required=255", last_vcyc - prev_vcyc); else passed++;
      checks++; if (v_duty !== 8'd100) $display("FAIL loop_duty2 actual=%0d required=100", v_duty); else passed++;
   endtask

   task automatic test_disable();
      bit ok;
      int base;
      base = last_vcyc;
      repeat (50) @(posedge clk);
      @(negedge clk);
      ena = 1'b0;
      @(negedge clk);
      checks++; if (valid !== 1'b0) $display("FAIL dis_valid actual=%b required=0", valid); else passed++;
      repeat (2) @(negedge clk);
      ena = 1'b1;
      checks++; if (duty !== 8'd100) $display("FAIL dis_hold_duty actual=%0d required=100", duty); else passed++;
      checks++; if (period !== 9'd255) $display("FAIL dis_hold_period actual=%0d required=255", period); else passed++;
      wait_valid(700, ok);
      checks++; if (!ok) $display("FAIL dis_wait actual=timeout required=valid"); else passed++;
      checks++; if (last_vcyc - base != 510) $display("FAIL dis_interval actual=%0d required=510", last_vcyc - base); else passed++;
      checks++; if (v_duty !== 8'd100) $display("FAIL dis_duty actual=%0d required=100", v_duty); else passed++;
      checks++; if (v_period !== 9'd255) $display("FAIL dis_period actual=%0d required=255", v_period); else passed++;
   endtask

   task automatic test_async_reset();
      repeat (20) @(posedge clk);
      checks++; if (duty !== 8'd100) $display("FAIL arst_pre_duty actual=%0d required=100", duty); else passed++;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++; if (duty !== 8'd0) $display("FAIL arst_duty actual=%0d required=0", duty); else passed++;
      checks++; if (period !== 9'd0) $display("FAIL arst_period actual=%0d required=0", period); else passed++;
      checks++; if (stuck !== 1'b0) $display("FAIL arst_stuck actual=%b required=0", stuck); else passed++;
      checks++; if (valid !== 1'b0) $display("FAIL arst_valid actual=%b required=0", valid); else passed++;
   endtask

   task automatic test_const_low();
      bit ok;
      do_reset(0, 0, 1, 1, 1);
      wait_valid(600, ok);
      checks++; if (!ok) $display("FAIL low_wait actual=timeout required=valid"); else passed++;
      checks++; if (v_duty !== 8'd0) $display("FAIL low_duty actual=%0d required=0", v_duty); else passed++;
      checks++; if (v_period !== 9'd0) $display("FAIL low_period actual=%0d required=0", v_period); else passed++;
      checks++; if (v_stuck !== 1'b1) $display("FAIL low_stuck actual=%b required=1", v_stuck); else passed++;
      wait_valid(600, ok);
      checks++; if (!ok) $display("FAIL low_wait2 actual=timeout required=valid"); else passed++;
      checks++; if (last_vcyc - prev_vcyc != 511) $display("FAIL low_interval actual=%0d required=511", last_vcyc - prev_vcyc); else passed++;
      checks++; if (v_stuck !== 1'b1) $display("FAIL low_stuck2 actual=%b required=1", v_stuck); else passed++;
   endtask

   task automatic test_const_high();
      bit ok;
      do_reset(1, 1, 1, 1, 1);
      wait_valid(700, ok);
      checks++; if (!ok) $display("FAIL high_wait actual=timeout required=valid"); else passed++;
      checks++; if (v_duty !== 8'd255) $display("FAIL high_duty actual=%0d required=255", v_duty); else passed++;
      checks++; if (v_period !== 9'd0) $display("FAIL high_period actual=%0d required=0", v_period); else passed++;
      checks++; if (v_stuck !== 1'b1) $display("FAIL high_stuck actual=%b required=1", v_stuck); else passed++;
      wait_valid(600, ok);
      checks++; if (!ok) $display("FAIL high_wait2 actual=timeout required=valid"); else passed++;
      checks++; if (last_vcyc - prev_vcyc != 511) $display("FAIL high_interval actual=%0d required=511", last_vcyc - prev_vcyc); else passed++;
      checks++; if (v_duty !== 8'd255) $display("FAIL high_duty2 actual=%0d required=255", v_duty); else passed++;
   endtask

   task automatic test_saturation();
      bit ok;
      do_reset(0, 2, 400, 10, 1);
      wait_valid(1000, ok);
      checks++; if (!ok) $display("FAIL sat_wait actual=timeout required=valid"); else passed++;
      checks++; if (v_duty !== 8'd255) $display("FAIL sat_duty actual=%0d required=255", v_duty); else passed++;
      checks++; if (v_period !== 9'd410) $display("FAIL sat_period actual=%0d required=410", v_period); else passed++;
      checks++; if (v_stuck !== 1'b0) $display("FAIL sat_stuck actual=%b required=0", v_stuck); else passed++;
   endtask

   task automatic test_min_duty();
      bit ok;
      do_reset(0, 2, 1, 254, 1);
      wait_valid(600, ok);
      checks++; if (!ok) $display("FAIL min_wait actual=timeout required=valid"); else passed++;
      checks++; if (v_duty !== 8'd1) $display("FAIL min_duty actual=%0d required=1", v_duty); else passed++;
      checks++; if (v_period !== 9'd255) $display("FAIL min_period actual=%0d required=255", v_period); else passed++;
   endtask

   task automatic test_single_gap();
      bit ok;
      do_reset(0, 2, 254, 1, 1);
      wait_valid(600, ok);
      checks++; if (!ok) $display("FAIL gap_wait actual=timeout required=valid"); else passed++;
      checks++; if (v_duty !== 8'd254) $display("FAIL gap_duty actual=%0d required=254", v_duty); else passed++;
      checks++; if (v_period !== 9'd255) $display("FAIL gap_period actual=%0d required=255", v_period); else passed++;
   endtask

   task automatic test_collision();
      bit ok;
      do_reset(0, 2, 1, 509, 1);
      wait_valid(1200, ok);
      checks++; if (!ok) $display("FAIL coll_wait actual=timeout required=valid"); else passed++;
      checks++; if (v_period !== 9'd510) $display("FAIL coll_period actual=%0d required=510", v_period); else passed++;
      checks++; if (v_stuck !== 1'b0) $display("FAIL coll_stuck actual=%b required=0", v_stuck); else passed++;
      checks++; if (v_duty !== 8'd1) $display("FAIL coll_duty actual=%0d required=1", v_duty); else passed++;
      wait_valid(600, ok);
      checks++; if (!ok) $display("FAIL coll_wait2 actual=timeout required=valid"); else passed++;
      checks++; if (last_vcyc - prev_vcyc != 510) $display("FAIL coll_interval actual=%0d required=510", last_vcyc - prev_vcyc); else passed++;
      checks++; if (v_stuck !== 1'b0) $display("FAIL coll_stuck2 actual=%b required=0", v_stuck); else passed++;
   endtask

   task automatic test_step_gating();
      bit ok;
      do_reset(0, 2, 80, 120, 4);
      gated_bad = 0;
      wait_valid(1000, ok);
      checks++; if (!ok) $display("FAIL gate_wait actual=timeout required=valid"); else passed++;
      checks++; if (v_duty !== 8'd20) $display("FAIL gate_duty actual=%0d required=20", v_duty); else passed++;
      checks++; if (v_period !== 9'd50) $display("FAIL gate_period actual=%0d required=50", v_period); else passed++;
      wait_valid(300, ok);
      checks++; if (!ok) $display("FAIL gate_wait2 actual=timeout required=valid"); else passed++;
      checks++; if (last_vcyc - prev_vcyc != 200) $display("FAIL gate_interval actual=%0d required=200", last_vcyc - prev_vcyc); else passed++;
      checks++; if (gated_bad != 0) $display("FAIL gate_offstep_valid actual=%0d required=0", gated_bad); else passed++;
   endtask

   initial begin
      fork
         drive_loop();
      join_none
      #1 rst = 1'b1;
      test_reset();
      test_loopback();
      test_disable();
      test_async_reset();
      test_const_low();
      test_const_high();
      test_saturation();
      test_min_duty();
      test_single_gap();
      test_collision();
      test_step_gating();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
